// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline control defines: FSM encodings and counter widths.
package pipe_ctrl_pkg;

    localparam int MC_W  = 4;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MCBUSY = 2'd1,
        HALT   = 2'd2
    } ctrl_state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

endpackage

// File: rtl/mc_down_counter.sv
// Remaining-latency down-counter for a multi-cycle EX operation.
module mc_down_counter
    import pipe_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [MC_W-1:0] value,
    input  logic            dec,
    output logic            zero_or_one
);

    logic [MC_W-1:0] cnt_q;
    logic [MC_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (dec) begin
            cnt_d = cnt_q - {{(MC_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_or_one = (cnt_q <= {{(MC_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: Mealy enables and flushes, multi-cycle
// EX tracking, halt handling and a saturating front-end stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             Need_Stall,
    input  logic             EX__BranchTaken,
    input  logic             EX__MC_Start,
    input  logic [MC_W-1:0]  EX__MC_Cycles,
    input  logic             MEM__Busy,
    input  logic             Halt_Req,
    input  logic             Resume,
    input  logic             Cnt_Clr,
    output logic             IF_En,
    output logic             ID_En,
    output logic             EX_En,
    output logic             MEM_En,
    output logic             WB_En,
    output logic             IFid_Flush,
    output logic             IDex_Flush,
    output logic             EXmem_Flush,
    output logic             MC_Done,
    output logic             Halted,
    output logic [CNT_W-1:0] Stall_Cnt
);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             mc_load;
    logic             mc_dec;
    logic             mc_last;

    mc_down_counter u_mc_cnt (
        .clk         (clk),
        .rst         (rst),
        .load        (mc_load),
        .value       (EX__MC_Cycles - {{(MC_W-1){1'b0}}, 1'b1}),
        .dec         (mc_dec),
        .zero_or_one (mc_last)
    );

    always_comb begin
        state_d     = state_q;
        IF_En       = 1'b1;
        ID_En       = 1'b1;
        EX_En       = 1'b1;
        MEM_En      = 1'b1;
        WB_En       = 1'b1;
        IFid_Flush  = 1'b0;
        IDex_Flush  = 1'b0;
        EXmem_Flush = 1'b0;
        MC_Done     = 1'b0;
        Halted      = 1'b0;
        mc_load     = 1'b0;
        mc_dec      = 1'b0;

        unique case (state_q)
            RUN: begin
                if (MEM__Busy) begin
                    {IF_En, ID_En, EX_En, MEM_En, WB_En} = 5'b0;
                end else if (Need_Stall) begin
                    {IF_En, ID_En, EX_En} = 3'b0;
                    EXmem_Flush = 1'b1;
                end else if (EX__MC_Start) begin
                    if (EX__MC_Cycles >= 4'd2) begin
                        {IF_En, ID_En, EX_En} = 3'b0;
                        EXmem_Flush = 1'b1;
                        mc_load     = 1'b1;
                        state_d     = MCBUSY;
                    end else begin
                        MC_Done = 1'b1;
                    end
                end else if (EX__BranchTaken) begin
                    IFid_Flush = 1'b1;
                    IDex_Flush = 1'b1;
                end else if (Halt_Req) begin
                    state_d = HALT;
                end
            end
            MCBUSY: begin
                if (MEM__Busy) begin
                    {IF_En, ID_En, EX_En, MEM_En, WB_En} = 5'b0;
                end else if (!mc_last) begin
                    {IF_En, ID_En, EX_En} = 3'b0;
                    EXmem_Flush = 1'b1;
                    mc_dec      = 1'b1;
                end else begin
                    MC_Done = 1'b1;
                    state_d = RUN;
                end
            end
            HALT: begin
                {IF_En, ID_En, EX_En, MEM_En, WB_En} = 5'b0;
                Halted = 1'b1;
                if (Resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Reset silences every control output without waiting for an edge.
        if (rst) begin
            {IF_En, ID_En, EX_En, MEM_En, WB_En} = 5'b0;
            {IFid_Flush, IDex_Flush, EXmem_Flush} = 3'b0;
            MC_Done = 1'b0;
            Halted  = 1'b0;
            mc_load = 1'b0;
            mc_dec  = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Cnt_Clr) begin
            stall_cnt_d = '0;
        end else if (!IF_En && state_q != HALT && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Stall_Cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Need_Stall = 1'b0;
    logic        EX__BranchTaken = 1'b0;
    logic        EX__MC_Start = 1'b0;
    logic [3:0]  EX__MC_Cycles = 4'd0;
    logic        MEM__Busy = 1'b0;
    logic        Halt_Req = 1'b0;
    logic        Resume = 1'b0;
    logic        Cnt_Clr = 1'b0;
    logic        IF_En, ID_En, EX_En, MEM_En, WB_En;
    logic        IFid_Flush, IDex_Flush, EXmem_Flush;
    logic        MC_Done, Halted;
    logic [15:0] Stall_Cnt;

    pipe_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .Need_Stall      (Need_Stall),
        .EX__BranchTaken (EX__BranchTaken),
        .EX__MC_Start    (EX__MC_Start),
        .EX__MC_Cycles   (EX__MC_Cycles),
        .MEM__Busy       (MEM__Busy),
        .Halt_Req        (Halt_Req),
        .Resume          (Resume),
        .Cnt_Clr         (Cnt_Clr),
        .IF_En           (IF_En),
        .ID_En           (ID_En),
        .EX_En           (EX_En),
        .MEM_En          (MEM_En),
        .WB_En           (WB_En),
        .IFid_Flush      (IFid_Flush),
        .IDex_Flush      (IDex_Flush),
        .EXmem_Flush     (EXmem_Flush),
        .MC_Done         (MC_Done),
        .Halted          (Halted),
        .Stall_Cnt       (Stall_Cnt)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] I_RST = 8'h80;
    localparam logic [7:0] I_NS  = 8'h40;
    localparam logic [7:0] I_BR  = 8'h20;
    localparam logic [7:0] I_MC  = 8'h10;
    localparam logic [7:0] I_BSY = 8'h08;
    localparam logic [7:0] I_HLT = 8'h04;
    localparam logic [7:0] I_RES = 8'h02;
    localparam logic [7:0] I_CLR = 8'h01;

    // {IF,ID,EX,MEM,WB, IFid,IDex,EXmem, MC_Done, Halted}
    localparam logic [9:0] O_DEF = 10'b11111_000_0_0;
    localparam logic [9:0] O_STL = 10'b00011_001_0_0;
    localparam logic [9:0] O_BSY = 10'b00000_000_0_0;
    localparam logic [9:0] O_BR  = 10'b11111_110_0_0;
    localparam logic [9:0] O_DON = 10'b11111_000_1_0;
    localparam logic [9:0] O_HLT = 10'b00000_000_0_1;
    localparam logic [9:0] O_RST = 10'b00000_000_0_0;

    typedef struct {
        logic [9:0]  outs;
        logic [15:0] cnt;
        int          id;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   vec   = 0;

    task automatic step(input logic [7:0] in, input logic [3:0] n,
                        input logic [9:0] eo, input logic [15:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = in[7];
        Need_Stall      = in[6];
        EX__BranchTaken = in[5];
        EX__MC_Start    = in[4];
        MEM__Busy       = in[3];
        Halt_Req        = in[2];
        Resume          = in[1];
        Cnt_Clr         = in[0];
        EX__MC_Cycles   = n;
        e.outs = eo;
        e.cnt  = ec;
        e.id   = vec;
        vec++;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [9:0] got;
        if (q.size() != 0) begin
            e = q.pop_front();
            got = {IF_En, ID_En, EX_En, MEM_En, WB_En,
                   IFid_Flush, IDex_Flush, EXmem_Flush, MC_Done, Halted};
            total++;
            if (got !== e.outs) begin
                bad++;
                $display("FAIL outs vec%0d got=%b want=%b", e.id, got, e.outs);
            end
            total++;
            if (Stall_Cnt !== e.cnt) begin
                bad++;
                $display("FAIL stall_cnt vec%0d got=%h want=%h",
                         e.id, Stall_Cnt, e.cnt);
            end
        end
    end

    initial begin
        // reset holds outputs low even with a hazard present
        step(I_RST | I_NS, 4'd0, O_RST, 16'd0);
        step(8'h00, 4'd0, O_DEF, 16'd0);
        // single load-use stall
        step(I_NS,  4'd0, O_STL, 16'd0);
        step(I_CLR, 4'd0, O_DEF, 16'd1);
        // N=4 multi-cycle op: 3 frozen cycles, done in the 4th
        step(I_MC,  4'd4, O_STL, 16'd0);
        step(8'h00, 4'd0, O_STL, 16'd1);
        step(8'h00, 4'd0, O_STL, 16'd2);
        step(8'h00, 4'd0, O_DON, 16'd3);
        step(8'h00, 4'd0, O_DEF, 16'd3);
        // N of 1 and 0 complete immediately
        step(I_MC,  4'd1, O_DON, 16'd3);
        step(I_MC,  4'd0, O_DON, 16'd3);
        // stall wins over branch; branch flush follows
        step(I_NS | I_BR, 4'd0, O_STL, 16'd3);
        step(I_BR,  4'd0, O_BR,  16'd4);
        step(8'h00, 4'd0, O_DEF, 16'd4);
        // MEM busy outranks everything, no state change
        step(I_BSY | I_NS | I_MC, 4'd5, O_BSY, 16'd4);
        step(8'h00, 4'd0, O_DEF, 16'd5);
        // N=5 with two busy cycles inside MCBUSY
        step(I_MC,  4'd5, O_STL, 16'd5);
        step(8'h00, 4'd0, O_STL, 16'd6);
        step(I_BSY, 4'd0, O_BSY, 16'd7);
        step(I_BSY | I_NS | I_BR | I_HLT, 4'd0, O_BSY, 16'd8);
        step(I_HLT | I_BR, 4'd0, O_STL, 16'd9);
        step(8'h00, 4'd0, O_STL, 16'd10);
        step(8'h00, 4'd0, O_DON, 16'd11);
        step(8'h00, 4'd0, O_DEF, 16'd11);
        // halt and resume; no counting while halted
        step(I_HLT, 4'd0, O_DEF, 16'd11);
        step(8'h00, 4'd0, O_HLT, 16'd11);
        step(I_HLT, 4'd0, O_HLT, 16'd11);
        step(I_RES, 4'd0, O_HLT, 16'd11);
        step(8'h00, 4'd0, O_DEF, 16'd11);
        step(I_BR | I_HLT, 4'd0, O_BR, 16'd11);
        step(8'h00, 4'd0, O_DEF, 16'd11);
        // reset mid-MCBUSY
        step(I_MC,  4'd8, O_STL, 16'd11);
        step(8'h00, 4'd0, O_STL, 16'd12);
        step(I_RST, 4'd0, O_RST, 16'd0);
        step(I_RST | I_NS, 4'd0, O_RST, 16'd0);
        step(8'h00, 4'd0, O_DEF, 16'd0);
        // reset while halted
        step(I_HLT, 4'd0, O_DEF, 16'd0);
        step(8'h00, 4'd0, O_HLT, 16'd0);
        step(I_RST, 4'd0, O_RST, 16'd0);
        step(8'h00, 4'd0, O_DEF, 16'd0);
        // clear beats increment
        step(I_NS,  4'd0, O_STL, 16'd0);
        step(I_NS | I_CLR, 4'd0, O_STL, 16'd1);
        step(8'h00, 4'd0, O_DEF, 16'd0);
        // 16'hFFFF + 1 stall cycles saturate the counter
        repeat (65536) begin
            @(posedge clk);
            #1;
            Need_Stall = 1'b1;
        end
        step(8'h00, 4'd0, O_DEF, 16'hFFFF);
        step(I_NS,  4'd0, O_STL, 16'hFFFF);
        step(I_CLR, 4'd0, O_DEF, 16'hFFFF);
        step(8'h00, 4'd0, O_DEF, 16'd0);

        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are named clk and rst.
REQ-002 Ports SHALL be as follows:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- Need_Stall  in  1  load-use hazard from the forwarding unit (EX waits on a load in MEM)
- EX__BranchTaken  in  1  taken branch or jump resolved in EX
- EX__MC_Start  in  1  multi-cycle op (mul/div) present in EX
- EX__MC_Cycles  in  4  latency N of that op
- MEM__Busy  in  1  data memory not ready
- Halt_Req  in  1  level halt request
- Resume  in  1  leave HALT
- Cnt_Clr  in  1  synchronous clear of the stall counter
- IF_En, ID_En, EX_En, MEM_En, WB_En  out  1 each  stage/register write enables (IF_En gates the PC)
- IFid_Flush, IDex_Flush, EXmem_Flush  out  1 each  insert a bubble into that pipeline register
- MC_Done  out  1  multi-cycle result released this cycle
- Halted  out  1  state is HALT
- Stall_Cnt  out  16  saturating count of front-end stall cycles

Function
REQ-003 The FSM SHALL have three states: RUN, MCBUSY and HALT, with a 4-bit down-counter mc_cnt.
REQ-004 All outputs SHALL be combinational functions of the state and the current inputs (Mealy), so a stall takes effect in the cycle it is raised.
REQ-005 Default outputs in RUN with no event SHALL be all enables 1 and all flushes 0.
REQ-006 Event priority in RUN SHALL be MEM__Busy > Need_Stall > EX__MC_Start > EX__BranchTaken > Halt_Req; only the highest-priority event acts in a given cycle.
REQ-007 MEM__Busy in RUN or MCBUSY SHALL drive all five enables to 0 and all flushes to 0, and SHALL change neither the state nor mc_cnt.
REQ-008 Need_Stall SHALL drive IF_En, ID_En and EX_En to 0, keep MEM_En and WB_En at 1, and set EXmem_Flush to 1 for that cycle only.
REQ-009 EX__MC_Start with N = EX__MC_Cycles >= 2 SHALL:
- apply the same freeze and bubble as REQ-008;
- load mc_cnt = N-1;
- move to MCBUSY.
REQ-010 EX__MC_Start with N of 0 or 1 SHALL cause no stall and SHALL raise MC_Done for that cycle.
REQ-011 In MCBUSY with mc_cnt > 1, the block SHALL apply the REQ-008 freeze and bubble and decrement mc_cnt.
REQ-012 In MCBUSY with mc_cnt == 1, the block SHALL drive all enables to 1, raise MC_Done and return to RUN; the total front-end freeze is therefore N-1 cycles.
REQ-013 EX__BranchTaken SHALL keep all enables at 1 (the PC loads the target) and set IFid_Flush and IDex_Flush to 1 for that cycle only.
REQ-014 Inputs other than MEM__Busy SHALL be ignored while in MCBUSY.
REQ-015 Halt_Req, when it is the acting event in RUN, SHALL give default outputs for that cycle and move to HALT on the next edge.
REQ-016 In HALT, all enables SHALL be 0 and Halted SHALL be 1.
REQ-017 Resume in HALT SHALL return the block to RUN on the next edge; Halt_Req is not examined in HALT.
REQ-018 Stall_Cnt SHALL increment by 1 in each cycle where IF_En == 0 and the state is not HALT, and SHALL saturate at 16'hFFFF.
REQ-019 Cnt_Clr SHALL zero Stall_Cnt on the next edge and takes priority over the increment.

Reset
REQ-020 While rst is high, the block SHALL force state = RUN, mc_cnt = 0 and Stall_Cnt = 0.
REQ-021 While rst is high, all enables, flushes, MC_Done and Halted SHALL be 0, asynchronously.
REQ-022 Reset asserted mid-MCBUSY or in HALT SHALL abandon the operation; after release the block is in RUN with default outputs.

Structure
REQ-023 State encodings (RUN=2'd0, MCBUSY=2'd1, HALT=2'd2) and the counter widths SHALL live in the shared pipeline defines package.
REQ-024 mc_cnt SHALL be implemented as a sub-module mc_down_counter with ports load, value, dec, zero_or_one.

Verification
REQ-025 Directed scenarios the bench SHALL cover:
- Need_Stall=1 for one cycle -> IF/ID/EX_En=0 and EXmem_Flush=1 for exactly that cycle; Stall_Cnt goes 0->1.
- EX__MC_Start with EX__MC_Cycles=4 -> front end frozen 3 cycles, MC_Done=1 in the 4th cycle, Stall_Cnt=3.
- EX__BranchTaken and Need_Stall together -> stall only; branch flush occurs in the cycle after Need_Stall drops.
- MEM__Busy for 2 cycles inside MCBUSY (N=5) -> all enables 0, mc_cnt held; MC_Done is delayed by 2 cycles.
- Halt_Req -> HALT on the next edge with Halted=1; Resume -> RUN; Stall_Cnt does not increment while halted.
- rst pulse mid-MCBUSY, then 16'hFFFF stall cycles plus one -> outputs 0 during reset and RUN after release; Stall_Cnt saturates at 16'hFFFF, and Cnt_Clr returns it to 0.
